reg_wb_queue: RTL and testbench

- Write-side counterpart of the register file: buffers retiring results (rd index + data) from the datapath and drives the register-file write port (rd_addr, rd_data, RegWrite), one write per cycle.
- Decouples multi-cycle producers (load unit, long-latency ALU ops) from the single register-file write port via a valid/ready push interface.
- Optionally provides a bypass lookup so register-file reads see pending, not-yet-written results.

---
 rtl/reg_wb_pkg.sv | 24 ++
 rtl/reg_wb_match.sv | 34 +++
 rtl/reg_wb_queue.sv | 99 +++++++++
 tb/tb_reg_wb_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_pkg.sv
// Shared widths and the queued write-back entry type for reg_wb_queue.
// DATA_WIDTH / REG_DEPTH may be overridden by the `DATA_WIDTH / `REG_DEPTH macros.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef REG_DEPTH
`define REG_DEPTH 32
`endif

package reg_wb_pkg;

    localparam int unsigned DATA_WIDTH = `DATA_WIDTH;
    localparam int unsigned REG_DEPTH  = `REG_DEPTH;
    localparam int unsigned QDEPTH     = 4;
    localparam int unsigned AW         = $clog2(REG_DEPTH);
    localparam int unsigned AW_Q       = $clog2(QDEPTH);
    localparam int unsigned CW         = AW_Q + 1;

    typedef struct packed {
        logic [AW-1:0]         addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/reg_wb_match.sv
// Youngest-match search over the pending queue entries, walked in age order
// starting at the head pointer.
module reg_wb_match
    import reg_wb_pkg::*;
(
    input  wb_entry_t              i_entries [QDEPTH],
    input  logic [AW_Q-1:0]        i_head,
    input  logic [CW-1:0]          i_count,
    input  logic [AW-1:0]          i_addr,
    output logic                   o_hit,
    output logic [DATA_WIDTH-1:0]  o_fwd
);

    logic [AW_Q-1:0] w_idx   [QDEPTH];
    logic            w_valid [QDEPTH];

    for (genvar g = 0; g < QDEPTH; g++) begin : g_age
        assign w_idx[g]   = i_head + AW_Q'(g);
        assign w_valid[g] = CW'(g) < i_count;
    end

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        o_hit = 1'b0;
        o_fwd = '0;
        for (int i = 0; i < int'(QDEPTH); i++) begin
            if (w_valid[i] && (i_addr != '0) && (i_entries[w_idx[i]].addr == i_addr)) begin
                o_hit = 1'b1;
                o_fwd = i_entries[w_idx[i]].data;
            end
        end
    end

endmodule

// File: rtl/reg_wb_queue.sv
// Write-back queue feeding the register-file write port, one write per cycle.
// Optional bypass lookup of pending results enabled by macro WB_BYPASS_EN.
module reg_wb_queue
    import reg_wb_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_valid_i,
    output logic                   push_ready_o,
    input  logic [AW-1:0]          push_addr_i,
    input  logic [DATA_WIDTH-1:0]  push_data_i,
    input  logic                   wb_hold_i,
    output logic [AW-1:0]          rd_addr_o,
    output logic [DATA_WIDTH-1:0]  rd_data_o,
    output logic                   RegWrite_o,
    input  logic [AW-1:0]          rs1_addr_i,
    input  logic [AW-1:0]          rs2_addr_i,
    output logic                   rs1_hit_o,
    output logic [DATA_WIDTH-1:0]  rs1_fwd_o,
    output logic                   rs2_hit_o,
    output logic [DATA_WIDTH-1:0]  rs2_fwd_o,
    output logic [CW-1:0]          count_o,
    output logic                   empty_o
);

    wb_entry_t       r_mem [QDEPTH];
    logic [AW_Q:0]   r_wr_ptr;
    logic [AW_Q:0]   r_rd_ptr;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [AW_Q-1:0] w_head;

    assign w_head  = r_rd_ptr[AW_Q-1:0];
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW_Q] != r_rd_ptr[AW_Q]) &&
                     (r_wr_ptr[AW_Q-1:0] == r_rd_ptr[AW_Q-1:0]);
    assign w_pop   = !w_empty && !wb_hold_i;
    // x0 pushes complete the handshake but are dropped.
    assign w_push  = push_valid_i && !w_full && (push_addr_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW_Q+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW_Q+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr[AW_Q-1:0]] <= '{addr: push_addr_i, data: push_data_i};
        end
    end

    assign push_ready_o = !w_full;
    assign RegWrite_o   = w_pop;
    assign rd_addr_o    = w_empty ? '0 : r_mem[w_head].addr;
    assign rd_data_o    = w_empty ? '0 : r_mem[w_head].data;
    assign count_o      = CW'(r_wr_ptr - r_rd_ptr);
    assign empty_o      = w_empty;

`ifdef WB_BYPASS_EN
    reg_wb_match u_match_rs1 (
        .i_entries (r_mem),
        .i_head    (w_head),
        .i_count   (count_o),
        .i_addr    (rs1_addr_i),
        .o_hit     (rs1_hit_o),
        .o_fwd     (rs1_fwd_o)
    );

    reg_wb_match u_match_rs2 (
        .i_entries (r_mem),
        .i_head    (w_head),
        .i_count   (count_o),
        .i_addr    (rs2_addr_i),
        .o_hit     (rs2_hit_o),
        .o_fwd     (rs2_fwd_o)
    );
`else
    logic w_unused_bypass;

    assign w_unused_bypass = ^{rs1_addr_i, rs2_addr_i};
    assign rs1_hit_o = 1'b0;
    assign rs1_fwd_o = '0;
    assign rs2_hit_o = 1'b0;
    assign rs2_fwd_o = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// Directed bench for reg_wb_queue: queue-based reference model checked every
// falling edge, plus literal expectations at key points of each scenario.
module tb_reg_wb_queue;
    import reg_wb_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  push_valid = 1'b0;
    logic                  push_ready;
    logic [AW-1:0]         push_addr = '0;
    logic [DATA_WIDTH-1:0] push_data = '0;
    logic                  wb_hold = 1'b0;
    logic [AW-1:0]         rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  reg_write;
    logic [AW-1:0]         rs1_addr = AW'(5);
    logic [AW-1:0]         rs2_addr = AW'(2);
    logic                  rs1_hit, rs2_hit;
    logic [DATA_WIDTH-1:0] rs1_fwd, rs2_fwd;
    logic [CW-1:0]         count;
    logic                  empty;

    int n_checks = 0;
    int n_fail = 0;
    int model_pops = 0;
    int obs_writes = 0;

    wb_entry_t mq[$];

    reg_wb_queue dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready),
        .push_addr_i  (push_addr),
        .push_data_i  (push_data),
        .wb_hold_i    (wb_hold),
        .rd_addr_o    (rd_addr),
        .rd_data_o    (rd_data),
        .RegWrite_o   (reg_write),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_hit_o    (rs1_hit),
        .rs1_fwd_o    (rs1_fwd),
        .rs2_hit_o    (rs2_hit),
        .rs2_fwd_o    (rs2_fwd),
        .count_o      (count),
        .empty_o      (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_lookup(input logic [AW-1:0] a, output logic hit,
                                         output logic [DATA_WIDTH-1:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WB_BYPASS_EN
        if (a != '0) begin
            foreach (mq[k]) begin
                if (mq[k].addr == a) begin
                    hit = 1'b1;
                    d   = mq[k].data;
                end
            end
        end
`endif
    endfunction

    // Reference model: FIFO of pending results, x0 dropped, no push while full.
    always @(posedge clk or negedge rst_n) begin : model
        bit m_ready;
        if (!rst_n) begin
            mq.delete();
        end else begin
            m_ready = mq.size() < QDEPTH;
            if (mq.size() != 0 && !wb_hold) begin
                mq.delete(0);
                model_pops++;
            end
            if (push_valid && m_ready && push_addr != '0)
                mq.push_back('{addr: push_addr, data: push_data});
        end
    end

    always @(negedge clk) begin : compare
        logic                  eh;
        logic [DATA_WIDTH-1:0] ed;
        bit                    ne;
        ne = mq.size() != 0;
        chk("push_ready", 64'(push_ready), 64'(mq.size() < QDEPTH));
        chk("reg_write",  64'(reg_write),  64'(ne && !wb_hold));
        chk("rd_addr",    64'(rd_addr),    ne ? 64'(mq[0].addr) : 64'(0));
        chk("rd_data",    64'(rd_data),    ne ? 64'(mq[0].data) : 64'(0));
        chk("count",      64'(count),      64'(mq.size()));
        chk("empty",      64'(empty),      64'(!ne));
        model_lookup(rs1_addr, eh, ed);
        chk("rs1_hit", 64'(rs1_hit), 64'(eh));
        chk("rs1_fwd", 64'(rs1_fwd), 64'(ed));
        model_lookup(rs2_addr, eh, ed);
        chk("rs2_hit", 64'(rs2_hit), 64'(eh));
        chk("rs2_fwd", 64'(rs2_fwd), 64'(ed));
        if (reg_write === 1'b1) obs_writes++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int a, input logic [DATA_WIDTH-1:0] d);
        push_valid = v;
        push_addr  = AW'(a);
        push_data  = d;
    endtask

    initial begin
        bit acc;
        int n;

        // Reset values
        #2;
        chk("rst_ready", 64'(push_ready), 64'(1));
        chk("rst_regwrite", 64'(reg_write), 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_rd_data", 64'(rd_data), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single push to empty queue: written the next cycle
        drive(1'b1, 5, 32'hDEADBEEF);
        chk("t1_pre_regwrite", 64'(reg_write), 64'(0));
        step();
        drive(1'b0, 0, '0);
        chk("t1_regwrite", 64'(reg_write), 64'(1));
        chk("t1_rd_addr", 64'(rd_addr), 64'(5));
        chk("t1_rd_data", 64'(rd_data), 64'(32'hDEADBEEF));
        step();
        chk("t1_empty", 64'(empty), 64'(1));
        chk("t1_regwrite_off", 64'(reg_write), 64'(0));

        // Fill under hold, then drain in order
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, DATA_WIDTH'(32'h11 * i));
            step();
        end
        drive(1'b0, 0, '0);
        chk("t2_full_ready", 64'(push_ready), 64'(0));
        chk("t2_full_count", 64'(count), 64'(4));
        chk("t2_held_regwrite", 64'(reg_write), 64'(0));
        wb_hold = 1'b0;
        #1;
        chk("t2_first_addr", 64'(rd_addr), 64'(1));
        chk("t2_first_ready", 64'(push_ready), 64'(0));
        for (int i = 2; i <= 4; i++) begin
            step();
            chk("t2_order_addr", 64'(rd_addr), 64'(i));
            chk("t2_order_data", 64'(rd_data), 64'(32'h11 * i));
            chk("t2_ready_after_pop", 64'(push_ready), 64'(1));
        end
        step();
        chk("t2_drained", 64'(empty), 64'(1));

        // x0 push: handshake but nothing enqueued
        drive(1'b1, 0, 32'hFFFFFFFF);
        chk("t3_ready", 64'(push_ready), 64'(1));
        step();
        drive(1'b0, 0, '0);
        chk("t3_count", 64'(count), 64'(0));
        chk("t3_regwrite", 64'(reg_write), 64'(0));
        step();
        chk("t3_regwrite2", 64'(reg_write), 64'(0));

        // Bypass: youngest of two pending writes to x7
        wb_hold = 1'b1;
        drive(1'b1, 7, 32'hA);
        step();
        drive(1'b1, 7, 32'hB);
        step();
        drive(1'b0, 0, '0);
        rs1_addr = AW'(7);
        rs2_addr = AW'(3);
        #1;
`ifdef WB_BYPASS_EN
        chk("t4_rs1_hit", 64'(rs1_hit), 64'(1));
        chk("t4_rs1_fwd", 64'(rs1_fwd), 64'(32'hB));
`else
        chk("t4_rs1_hit", 64'(rs1_hit), 64'(0));
        chk("t4_rs1_fwd", 64'(rs1_fwd), 64'(0));
`endif
        chk("t4_rs2_hit", 64'(rs2_hit), 64'(0));
        rs1_addr = AW'(0);
        #1;
        chk("t4_x0_hit", 64'(rs1_hit), 64'(0));
        rs1_addr = AW'(7);
        wb_hold = 1'b0;
        step();
        chk("t4_first_data", 64'(rd_data), 64'(32'hB));
        step();
        step();

        // Full queue with continuous pushes across several pointer wraps
        wb_hold = 1'b1;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, (n % 31) + 1, DATA_WIDTH'(32'h1000 + n));
            n++;
            step();
        end
        wb_hold = 1'b0;
        drive(1'b1, (n % 31) + 1, DATA_WIDTH'(32'h1000 + n));
        for (int c = 0; c < 26; c++) begin
            acc = push_ready;
            step();
            if (acc) begin
                n++;
                drive(1'b1, (n % 31) + 1, DATA_WIDTH'(32'h1000 + n));
            end
        end
        drive(1'b0, 0, '0);
        for (int c = 0; c < 6; c++) step();
        chk("t5_drained", 64'(empty), 64'(1));

        // Async reset mid-drain with 3 pending entries
        wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 9 + i, DATA_WIDTH'(32'h900 + i));
            step();
        end
        drive(1'b0, 0, '0);
        wb_hold = 1'b0;
        #1;
        chk("t6_pre_regwrite", 64'(reg_write), 64'(1));
        chk("t6_pre_count", 64'(count), 64'(3));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_regwrite", 64'(reg_write), 64'(0));
        chk("t6_rst_count", 64'(count), 64'(0));
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t6_no_stale", 64'(reg_write), 64'(0));
        end

        chk("write_count", 64'(obs_writes), 64'(model_pops));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
